enemy_ctrl: RTL and testbench
=============================

ENEMY_CTRL -- requirements
Module: enemy_ctrl

Interface
REQ-001 SHALL have parameters: SPAWN_X 632 (enemy spawn column); EXPLODE_TICKS 200 (explosion duration, ticks); RESPAWN_TICKS 500 (delay before respawn, ticks); ENEMY_SIZE 16 (enemy box edge, px).
REQ-002 SHALL have ports:
clk_1ms  input  1  game tick clock, all state updates on its rising edge
reset  input  1  synchronous, active-low
game_state  input  2  2'b01 = playing; any other value = not playing
x_rocket  input  10  rocket centre x, from rocket stage
y_rocket  input  10  rocket centre y, from rocket stage
x_ship  input  10  ship centre x
x  input  10  current pixel x
y  input  10  current pixel y
x_enemy  output  10  enemy centre x
y_enemy  output  10  enemy centre y
enemy_on  output  1  pixel (x,y) is inside the visible enemy box
rgb_enemy  output  12  enemy pixel colour
hit_pulse  output  1  one-tick pulse on rocket/enemy collision
miss_pulse  output  1  one-tick pulse when the enemy reaches the left edge
score  output  8  hit count, saturating

Function
REQ-003 SHALL implement a 4-state FSM: IDLE, MOVE, EXPLODE, WAIT.
REQ-004 SHALL implement an 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5, advancing every tick in every state.
REQ-005 IDLE: while game_state==2'b01, next tick SHALL load x_enemy=SPAWN_X, y_enemy=48+lfsr (range 48..303), and enter MOVE.
REQ-006 MOVE: SHALL decrement x_enemy by 1 each tick; y_enemy held.
REQ-007 Rocket in flight SHALL be defined as x_rocket != x_ship.
REQ-008 Hit condition SHALL be: in MOVE, rocket in flight, |x_rocket-x_enemy| < ENEMY_SIZE and |y_rocket-y_enemy| < ENEMY_SIZE; differences SHALL be computed unsigned with no 10-bit wrap (compare larger minus smaller).
REQ-009 On hit: hit_pulse=1 for exactly that tick, score+1 saturating at 255, position frozen, enter EXPLODE with counter cleared.
REQ-010 Miss condition SHALL be: in MOVE, x_enemy <= 8 and no hit; miss_pulse=1 for one tick, enter WAIT with counter cleared.
REQ-011 Hit and miss in the same tick: hit SHALL win; miss_pulse stays 0.
REQ-012 EXPLODE: after EXPLODE_TICKS ticks SHALL enter WAIT with counter cleared.
REQ-013 WAIT: after RESPAWN_TICKS ticks SHALL respawn as in REQ-005 and enter MOVE.
REQ-014 game_state != 2'b01 in any state: next tick SHALL enter IDLE, clear counter, hold x_enemy/y_enemy and score; no pulses.
REQ-015 enemy_on SHALL be combinational: state is MOVE or EXPLODE and x in [x_enemy-8, x_enemy+8] and y in [y_enemy-8, y_enemy+8].
REQ-016 rgb_enemy SHALL be 12'hF00 in MOVE; in EXPLODE 12'hFF0 while counter[4]==0, else 12'hF80.
REQ-017 hit_pulse and miss_pulse SHALL be registered and never both high.

Reset
REQ-018 reset==0 at a clk_1ms edge SHALL force: state IDLE, counter 0, lfsr 8'hA5, x_enemy=SPAWN_X, y_enemy=48, score 0, hit_pulse 0, miss_pulse 0; reset mid-EXPLODE/WAIT SHALL abort without any pulse.

Verification
REQ-019 Spawn: release reset, game_state=01 -> after 1 tick state MOVE, x_enemy=632; after 100 further ticks x_enemy=532.
REQ-020 Hit: enemy at (400,200), x_ship=50, x_rocket=390, y_rocket=205 -> hit_pulse one tick, score 0->1, enemy_on remains 1 for 200 ticks, then 0 for 500 ticks, then respawn at x=632.
REQ-021 No hit when idle rocket: x_rocket=x_ship=400 over the enemy -> no hit_pulse, x_enemy keeps decrementing.
REQ-022 Miss: no rocket, enemy from 632 -> miss_pulse on the tick x_enemy reaches 8, score unchanged, WAIT entered.
REQ-023 Saturation and simultaneous event: preload score 255, hit at x_enemy=8 -> hit_pulse=1, miss_pulse=0, score stays 255.
REQ-024 Game pause: game_state=10 mid-MOVE -> IDLE next tick, enemy_on=0, position and score held; returning to 01 respawns at 632.

Source files
------------

// File: rtl/enemy_ctrl.sv
// Enemy sprite controller: spawns an enemy at the right edge, walks it left,
// detects rocket hits and edge misses, runs explode/respawn timers and keeps score.
module enemy_ctrl #(
   parameter int unsigned SPAWN_X       = 632,
   parameter int unsigned EXPLODE_TICKS = 200,
   parameter int unsigned RESPAWN_TICKS = 500,
   parameter int unsigned ENEMY_SIZE    = 16
) (
   input  logic        clk_1ms,
   input  logic        reset,
   input  logic [1:0]  game_state,
   input  logic [9:0]  x_rocket,
   input  logic [9:0]  y_rocket,
   input  logic [9:0]  x_ship,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   output logic [9:0]  x_enemy,
   output logic [9:0]  y_enemy,
   output logic        enemy_on,
   output logic [11:0] rgb_enemy,
   output logic        hit_pulse,
   output logic        miss_pulse,
   output logic [7:0]  score
);

   localparam int unsigned CNT_MAX  = (EXPLODE_TICKS > RESPAWN_TICKS) ? EXPLODE_TICKS : RESPAWN_TICKS;
   // Counter must be at least 5 bits because bit 4 drives the explosion flicker.
   localparam int unsigned CNT_W    = ($clog2(CNT_MAX) > 5) ? $clog2(CNT_MAX) : 5;
   localparam int unsigned HALF_BOX = 8;
   localparam int unsigned Y_BASE   = 48;
   localparam int unsigned EDGE_X   = 8;

   typedef enum logic [1:0] {IDLE, MOVE, EXPLODE, WAIT} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         lfsr_q, lfsr_d;
   logic [9:0]         x_enemy_q, x_enemy_d;
   logic [9:0]         y_enemy_q, y_enemy_d;
   logic [7:0]         score_q, score_d;
   logic               hit_q, hit_d;
   logic               miss_q, miss_d;

   logic               playing_c;
   logic               in_flight_c;
   logic [9:0]         dx_c, dy_c;
   logic               hit_c, miss_c;
   logic [9:0]         spawn_y_c;
   logic               visible_c;
   logic [10:0]        px_c, py_c, ex_c, ey_c;

   // Collision distances use larger-minus-smaller so no 10-bit wrap occurs.
   always_comb begin
      playing_c   = (game_state == 2'b01);
      in_flight_c = (x_rocket != x_ship);
      dx_c        = (x_rocket >= x_enemy_q) ? (x_rocket - x_enemy_q) : (x_enemy_q - x_rocket);
      dy_c        = (y_rocket >= y_enemy_q) ? (y_rocket - y_enemy_q) : (y_enemy_q - y_rocket);
      hit_c       = (state_q == MOVE) && in_flight_c &&
                    (dx_c < 10'(ENEMY_SIZE)) && (dy_c < 10'(ENEMY_SIZE));
      miss_c      = (state_q == MOVE) && (x_enemy_q <= 10'(EDGE_X)) && !hit_c;
      spawn_y_c   = 10'(Y_BASE) + {2'b00, lfsr_q};
   end

   // Next-state logic; the LFSR free-runs in every state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      x_enemy_d = x_enemy_q;
      y_enemy_d = y_enemy_q;
      score_d   = score_q;
      hit_d     = 1'b0;
      miss_d    = 1'b0;
      if (!playing_c) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               x_enemy_d = 10'(SPAWN_X);
               y_enemy_d = spawn_y_c;
               cnt_d     = '0;
               state_d   = MOVE;
            end
            MOVE: begin
               if (hit_c) begin
                  hit_d   = 1'b1;
                  score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                  cnt_d   = '0;
                  state_d = EXPLODE;
               end else if (miss_c) begin
                  miss_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = WAIT;
               end else begin
                  x_enemy_d = x_enemy_q - 10'd1;
               end
            end
            EXPLODE: begin
               if (cnt_q == CNT_W'(EXPLODE_TICKS - 1)) begin
                  cnt_d   = '0;
                  state_d = WAIT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            WAIT: begin
               if (cnt_q == CNT_W'(RESPAWN_TICKS - 1)) begin
                  x_enemy_d = 10'(SPAWN_X);
                  y_enemy_d = spawn_y_c;
                  cnt_d     = '0;
                  state_d   = MOVE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_1ms) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         lfsr_q    <= 8'hA5;
         x_enemy_q <= 10'(SPAWN_X);
         y_enemy_q <= 10'(Y_BASE);
         score_q   <= 8'd0;
         hit_q     <= 1'b0;
         miss_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lfsr_q    <= lfsr_d;
         x_enemy_q <= x_enemy_d;
         y_enemy_q <= y_enemy_d;
         score_q   <= score_d;
         hit_q     <= hit_d;
         miss_q    <= miss_d;
      end
   end

   // Pixel box test widened to 11 bits so the +/-8 bounds never wrap.
   always_comb begin
      px_c      = {1'b0, x};
      py_c      = {1'b0, y};
      ex_c      = {1'b0, x_enemy_q};
      ey_c      = {1'b0, y_enemy_q};
      visible_c = (state_q == MOVE) || (state_q == EXPLODE);
      enemy_on  = visible_c &&
                  (px_c + 11'(HALF_BOX) >= ex_c) && (px_c <= ex_c + 11'(HALF_BOX)) &&
                  (py_c + 11'(HALF_BOX) >= ey_c) && (py_c <= ey_c + 11'(HALF_BOX));
      rgb_enemy = 12'h000;
      if (state_q == MOVE) begin
         rgb_enemy = 12'hF00;
      end else if (state_q == EXPLODE) begin
         rgb_enemy = cnt_q[4] ? 12'hF80 : 12'hFF0;
      end
   end

   assign x_enemy    = x_enemy_q;
   assign y_enemy    = y_enemy_q;
   assign hit_pulse  = hit_q;
   assign miss_pulse = miss_q;
   assign score      = score_q;

endmodule

// File: tb/tb_enemy_ctrl.sv
// Bench for enemy_ctrl: two instances (default timers and short timers) run in
// lockstep against a behavioural model, with directed scenarios and random play.
module tb_enemy_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [1:0]  gs;
   logic [9:0]  xr, yr, xs, px, py;
   logic [9:0]  xe [2];
   logic [9:0]  ye [2];
   logic        on [2];
   logic [11:0] rgb [2];
   logic        hp [2];
   logic        mp [2];
   logic [7:0]  sc [2];

   enemy_ctrl dut0 (
      .clk_1ms(clk), .reset(reset), .game_state(gs), .x_rocket(xr), .y_rocket(yr),
      .x_ship(xs), .x(px), .y(py), .x_enemy(xe[0]), .y_enemy(ye[0]), .enemy_on(on[0]),
      .rgb_enemy(rgb[0]), .hit_pulse(hp[0]), .miss_pulse(mp[0]), .score(sc[0])
   );

   enemy_ctrl #(.EXPLODE_TICKS(4), .RESPAWN_TICKS(6)) dut1 (
      .clk_1ms(clk), .reset(reset), .game_state(gs), .x_rocket(xr), .y_rocket(yr),
      .x_ship(xs), .x(px), .y(py), .x_enemy(xe[1]), .y_enemy(ye[1]), .enemy_on(on[1]),
      .rgb_enemy(rgb[1]), .hit_pulse(hp[1]), .miss_pulse(mp[1]), .score(sc[1])
   );

   int checks = 0;
   int errors = 0;

   // Model state per instance; modes: 0 idle, 1 moving, 2 exploding, 3 waiting.
   localparam int M_IDLE = 0, M_MOVE = 1, M_EXPL = 2, M_WAIT = 3;
   int m_mode [2];
   int m_x    [2];
   int m_y    [2];
   int m_sc   [2];
   int m_t    [2];
   int m_lf   [2];
   int m_hit  [2];
   int m_miss [2];
   int m_e    [2] = '{200, 4};
   int m_r    [2] = '{500, 6};

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   task automatic model_step(input int i);
      int lf;
      int xrv, yrv, xsv;
      lf  = m_lf[i];
      xrv = int'(xr); yrv = int'(yr); xsv = int'(xs);
      m_hit[i]  = 0;
      m_miss[i] = 0;
      if (!reset) begin
         m_mode[i] = M_IDLE; m_t[i] = 0; m_lf[i] = 8'hA5;
         m_x[i] = 632; m_y[i] = 48; m_sc[i] = 0;
         return;
      end
      m_lf[i] = ((lf << 1) & 255) | (((lf >> 7) ^ (lf >> 5) ^ (lf >> 4) ^ (lf >> 3)) & 1);
      if (gs != 2'b01) begin
         m_mode[i] = M_IDLE; m_t[i] = 0;
         return;
      end
      case (m_mode[i])
         M_IDLE: begin m_x[i] = 632; m_y[i] = 48 + lf; m_t[i] = 0; m_mode[i] = M_MOVE; end
         M_MOVE: begin
            if (xrv != xsv && absd(xrv, m_x[i]) < 16 && absd(yrv, m_y[i]) < 16) begin
               m_hit[i] = 1;
               if (m_sc[i] < 255) m_sc[i]++;
               m_t[i] = 0; m_mode[i] = M_EXPL;
            end else if (m_x[i] <= 8) begin
               m_miss[i] = 1; m_t[i] = 0; m_mode[i] = M_WAIT;
            end else begin
               m_x[i]--;
            end
         end
         M_EXPL: begin
            m_t[i]++;
            if (m_t[i] == m_e[i]) begin m_t[i] = 0; m_mode[i] = M_WAIT; end
         end
         default: begin
            m_t[i]++;
            if (m_t[i] == m_r[i]) begin
               m_x[i] = 632; m_y[i] = 48 + lf; m_t[i] = 0; m_mode[i] = M_MOVE;
            end
         end
      endcase
   endtask

   function automatic int exp_on(input int i);
      int a, b;
      a = int'(px); b = int'(py);
      if (m_mode[i] != M_MOVE && m_mode[i] != M_EXPL) return 0;
      return (a >= m_x[i] - 8 && a <= m_x[i] + 8 && b >= m_y[i] - 8 && b <= m_y[i] + 8) ? 1 : 0;
   endfunction

   function automatic int exp_rgb(input int i);
      if (m_mode[i] == M_MOVE) return 12'hF00;
      if (m_mode[i] == M_EXPL) return ((m_t[i] / 16) % 2 == 1) ? 12'hF80 : 12'hFF0;
      return 0;
   endfunction

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("x_enemy%0d", i), int'(xe[i]), m_x[i]);
         check($sformatf("y_enemy%0d", i), int'(ye[i]), m_y[i]);
         check($sformatf("score%0d", i), int'(sc[i]), m_sc[i]);
         check($sformatf("hit_pulse%0d", i), int'(hp[i]), m_hit[i]);
         check($sformatf("miss_pulse%0d", i), int'(mp[i]), m_miss[i]);
         check($sformatf("enemy_on%0d", i), int'(on[i]), exp_on(i));
         check($sformatf("rgb%0d", i), int'(rgb[i]), exp_rgb(i));
         check($sformatf("pulse_excl%0d", i), int'(hp[i] & mp[i]), 0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      compare_all();
   endtask

   task automatic rocket_idle();
      xs = 10'd50; xr = 10'd50; yr = 10'd400;
   endtask

   int saved_x, saved_sc, n;

   initial begin
      reset = 1'b0; gs = 2'b00; px = 10'd0; py = 10'd0;
      rocket_idle();
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = M_IDLE; m_x[i] = 0; m_y[i] = 0; m_sc[i] = 0;
         m_t[i] = 0; m_lf[i] = 0; m_hit[i] = 0; m_miss[i] = 0;
      end
      tick(); tick();
      check("rst_x", int'(xe[0]), 632);
      check("rst_y", int'(ye[0]), 48);
      check("rst_score", int'(sc[0]), 0);

      // Spawn and march
      reset = 1'b1; gs = 2'b01;
      tick();
      check("spawn_x", int'(xe[0]), 632);
      check("spawn_y", int'(ye[0]), 48 + 8'hA5);
      repeat (100) tick();
      check("march_x", int'(xe[0]), 532);

      // Rocket parked on the ship over the enemy never hits
      saved_x = int'(xe[0]);
      for (int k = 0; k < 5; k++) begin
         xr = xe[0]; xs = xe[0]; yr = ye[0]; px = xe[0]; py = ye[0];
         tick();
         check("idle_rocket_hit", int'(hp[0]), 0);
      end
      check("idle_rocket_x", int'(xe[0]), saved_x - 5);

      // Pause mid-move
      rocket_idle();
      saved_x = int'(xe[0]); px = xe[0]; py = ye[0];
      gs = 2'b10;
      tick();
      check("pause_on", int'(on[0]), 0);
      check("pause_x", int'(xe[0]), saved_x);
      repeat (3) tick();
      check("pause_hold_x", int'(xe[0]), saved_x);
      gs = 2'b01;
      tick();
      check("resume_x", int'(xe[0]), 632);

      // Hit, explode for EXPLODE_TICKS, wait RESPAWN_TICKS, respawn
      n = 0;
      while (!(m_mode[0] == M_MOVE && m_x[0] <= 500) && n < 2000) begin tick(); n++; end
      check("wait_hit_ready", (n < 2000) ? 1 : 0, 1);
      saved_sc = m_sc[0];
      xs = 10'd50; xr = 10'(m_x[0] - 10); yr = 10'(m_y[0] + 5);
      px = 10'(m_x[0]); py = 10'(m_y[0]);
      tick();
      check("hit_pulse", int'(hp[0]), 1);
      check("hit_score", int'(sc[0]), saved_sc + 1);
      saved_x = int'(xe[0]);
      rocket_idle();
      tick();
      check("hit_pulse_one", int'(hp[0]), 0);
      repeat (198) tick();
      check("explode_on_end", int'(on[0]), 1);
      check("explode_x_frozen", int'(xe[0]), saved_x);
      tick();
      check("wait_on", int'(on[0]), 0);
      repeat (499) tick();
      check("wait_end_x", int'(xe[0]), saved_x);
      tick();
      check("respawn_x", int'(xe[0]), 632);

      // Miss at the left edge
      saved_sc = int'(sc[0]);
      n = 0;
      while (m_miss[0] == 0 && n < 1000) begin tick(); n++; end
      check("miss_seen", int'(mp[0]), 1);
      check("miss_x", int'(xe[0]), 8);
      check("miss_score", int'(sc[0]), saved_sc);

      // Drive the short-timer instance to a saturated score
      n = 0;
      while (m_sc[1] < 255 && n < 30000) begin
         if (m_mode[1] == M_MOVE) begin
            xs = 10'd50; xr = 10'(m_x[1]); yr = 10'(m_y[1]);
         end else begin
            rocket_idle();
         end
         tick(); n++;
      end
      check("sat_score", int'(sc[1]), 255);

      // Hit and edge miss on the same tick at full score
      rocket_idle();
      n = 0;
      while (!(m_mode[1] == M_MOVE && m_x[1] == 8) && n < 3000) begin tick(); n++; end
      check("edge_ready", (n < 3000) ? 1 : 0, 1);
      xs = 10'd50; xr = 10'd8; yr = 10'(m_y[1]);
      tick();
      check("simul_hit", int'(hp[1]), 1);
      check("simul_miss", int'(mp[1]), 0);
      check("simul_score", int'(sc[1]), 255);

      // Random play with occasional resets and pauses
      for (int k = 0; k < 4000; k++) begin
         int d;
         reset = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
         gs = ($urandom_range(0, 99) < 3) ? 2'($urandom_range(0, 3)) : 2'b01;
         xs = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 1) == 1) begin
            d = int'($urandom_range(0, 40)) - 20; xr = 10'(m_x[k % 2] + d);
            d = int'($urandom_range(0, 40)) - 20; yr = 10'(m_y[k % 2] + d);
         end else begin
            xr = 10'($urandom_range(0, 1023)); yr = 10'($urandom_range(0, 1023));
         end
         if ($urandom_range(0, 1) == 1) begin
            d = int'($urandom_range(0, 20)) - 10; px = 10'(m_x[0] + d);
            d = int'($urandom_range(0, 20)) - 10; py = 10'(m_y[0] + d);
         end else begin
            px = 10'($urandom_range(0, 1023)); py = 10'($urandom_range(0, 1023));
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
